slot_demux8: RTL and testbench

- One-to-eight steering and allocation unit, the write side of the 8-entry selection path.
- Accepts a payload on a valid/ready handshake and writes it into the lowest-index free slot of an 8-entry holding array.
- Holds each slot busy until an explicit release arrives.
- Downstream 8:1 selectors read the slot array by 3-bit index; this block is the only writer of that array.

---
 rtl/slot_demux8_pkg.sv | 19 +
 rtl/slot_demux8_prio_enc8.sv | 21 ++
 rtl/slot_demux8.sv | 85 ++++++++
 tb/tb_slot_demux8.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/slot_demux8_pkg.sv
// Shared sizing, types and helpers for the 8-entry slot allocator.
package slot_demux8_pkg;

  localparam int NSLOT      = 8;
  localparam int SLOT_IDX_W = 3;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
  typedef logic [NSLOT-1:0]      slot_vec_t;

  function automatic logic [3:0] popcount8(input slot_vec_t v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/slot_demux8_prio_enc8.sv
// Lowest-index-first priority encoder over an 8-bit request vector.
module prio_enc8
  import slot_demux8_pkg::*;
(
  input  slot_vec_t req,
  output slot_idx_t idx,
  output logic      any
);

  // Scan from the top down so the lowest set bit is the last to overwrite idx.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = slot_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/slot_demux8.sv
// Write side of the 8-entry selection path: stores each accepted payload in the
// lowest free slot and holds it busy until an explicit per-slot release.
module slot_demux8
  import slot_demux8_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [NSLOT-1:0]        slot_release,
  output logic [NSLOT-1:0]        slot_busy,
  output logic [NSLOT*DATA_W-1:0] slot_data,
  output logic                    alloc_fire,
  output logic [SLOT_IDX_W-1:0]   alloc_idx,
  output logic [3:0]              count
);

  slot_vec_t         busy_reg, busy_next;
  slot_vec_t         alloc_mask;
  slot_idx_t         sel;
  slot_idx_t         alloc_idx_reg;
  logic              any_free;
  logic              fire;
  logic              alloc_fire_reg;
  logic [3:0]        count_reg, count_next;
  logic [DATA_W-1:0] data_reg [NSLOT];

  prio_enc8 u_prio_enc8 (
    .req (~busy_reg),
    .idx (sel),
    .any (any_free)
  );

  assign in_ready = any_free;
  assign fire     = in_valid & any_free;

  // Slot choice uses the pre-release vector, so a slot being freed this edge
  // can never be the one allocated; releases of free slots fall out of the AND.
  always_comb begin
    alloc_mask = '0;
    if (fire) begin
      alloc_mask[sel] = 1'b1;
    end
    busy_next  = (busy_reg & ~slot_release) | alloc_mask;
    count_next = count_reg + {3'b000, fire} - popcount8(slot_release & busy_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg       <= '0;
      count_reg      <= '0;
      alloc_fire_reg <= 1'b0;
      alloc_idx_reg  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        data_reg[i] <= '0;
      end
    end else begin
      busy_reg       <= busy_next;
      count_reg      <= count_next;
      alloc_fire_reg <= fire;
      if (fire) begin
        data_reg[sel] <= in_data;
        alloc_idx_reg <= sel;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot_out
      assign slot_data[gi*DATA_W +: DATA_W] = data_reg[gi];
    end
  endgenerate

  assign slot_busy  = busy_reg;
  assign alloc_fire = alloc_fire_reg;
  assign alloc_idx  = alloc_idx_reg;
  assign count      = count_reg;

  count_matches_busy: assert property (@(posedge clk) disable iff (reset)
    count_reg == popcount8(busy_reg));

endmodule

// File: tb/tb_slot_demux8.sv
// Scoreboard bench for slot_demux8: directed scenarios then random traffic,
// checked against a slot-array model and a queue of expected allocations.
module tb_slot_demux8;

  localparam int DW = 16;
  localparam int NS = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [NS-1:0]  slot_release;
  logic [NS-1:0]  slot_busy;
  logic [NS*DW-1:0] slot_data;
  logic           alloc_fire;
  logic [2:0]     alloc_idx;
  logic [3:0]     count;

  slot_demux8 #(.DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .slot_release (slot_release),
    .slot_busy    (slot_busy),
    .slot_data    (slot_data),
    .alloc_fire   (alloc_fire),
    .alloc_idx    (alloc_idx),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // Model: which slots hold data, what they hold, and the last allocation.
  bit            m_busy [NS];
  logic [DW-1:0] m_data [NS];
  bit            m_fire;
  int            m_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < NS; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_busy"},  64'(slot_busy),  64'(model_vec()));
    chk({tag, "_count"}, 64'(count),      64'(model_count()));
    chk({tag, "_ready"}, 64'(in_ready),   64'(model_count() != NS));
    chk({tag, "_fire"},  64'(alloc_fire), 64'(m_fire));
    chk({tag, "_idx"},   64'(alloc_idx),  64'(m_idx));
    for (int i = 0; i < NS; i++)
      chk($sformatf("%s_data%0d", tag, i), 64'(slot_data[i*DW +: DW]), 64'(m_data[i]));
  endtask

  // One clock of stimulus; the model decides what this edge should do.
  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [DW-1:0] d, input logic [NS-1:0] rel);
    int  sel;
    bit  fire;
    reset = rst; in_valid = v; in_data = d; slot_release = rel;
    fire = 1'b0;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin m_busy[i] = 1'b0; m_data[i] = '0; end
      m_idx = 0;
      exp_q.delete();
    end else begin
      sel = -1;
      for (int i = 0; i < NS; i++) if (!m_busy[i] && sel < 0) sel = i;
      fire = v && (sel >= 0);
      for (int i = 0; i < NS; i++) if (rel[i]) m_busy[i] = 1'b0;
      if (fire) begin
        m_busy[sel] = 1'b1;
        m_data[sel] = d;
        m_idx = sel;
        exp_q.push_back('{idx: 3'(sel), data: d});
      end
    end
    m_fire = fire;
    @(posedge clk);
    #1;
    check_state(tag);
    $display("[TB] %s rst=%0b v=%0b d=%h rel=%h -> busy=%h count=%0d fire=%0b idx=%0d",
             tag, rst, v, d, rel, slot_busy, count, alloc_fire, alloc_idx);
  endtask

  // Monitor: every presented allocation must match the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && alloc_fire === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_fire", 64'(alloc_idx), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_idx",  64'(alloc_idx), 64'(e.idx));
        chk("mon_data", 64'(slot_data[e.idx*DW +: DW]), 64'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; slot_release = '0;

    step("rst0", 1'b1, 1'b1, 16'h1234, 8'hFF);
    step("rst1", 1'b1, 1'b1, 16'h1234, 8'hFF);
    chk("rst_busy",  64'(slot_busy),  64'h0);
    chk("rst_count", 64'(count),      64'h0);
    chk("rst_fire",  64'(alloc_fire), 64'h0);
    chk("rst_ready", 64'(in_ready),   64'h1);

    for (int k = 0; k < NS; k++) step("fill", 1'b0, 1'b1, DW'(16'hA000 + k), 8'h00);
    chk("fill_busy",  64'(slot_busy), 64'hFF);
    chk("fill_count", 64'(count),     64'h8);
    chk("fill_ready", 64'(in_ready),  64'h0);
    step("full_hold", 1'b0, 1'b1, 16'hA008, 8'h00);

    step("hole_rel", 1'b0, 1'b0, 16'h0, 8'b0010_0100);
    chk("hole_busy",  64'(slot_busy), 64'hDB);
    chk("hole_count", 64'(count),     64'h6);
    step("hole_a", 1'b0, 1'b1, 16'hB000, 8'h00);
    chk("hole_a_idx", 64'(alloc_idx), 64'h2);
    step("hole_b", 1'b0, 1'b1, 16'hB001, 8'h00);
    chk("hole_b_idx", 64'(alloc_idx), 64'h5);

    step("fullrel", 1'b0, 1'b1, 16'hC000, 8'h08);
    chk("fullrel_nofire", 64'(alloc_fire), 64'h0);
    step("fullrel_w", 1'b0, 1'b1, 16'hC000, 8'h00);
    chk("fullrel_idx", 64'(alloc_idx), 64'h3);

    step("sim_prep", 1'b0, 1'b0, 16'h0, 8'hFE);
    step("sim", 1'b0, 1'b1, 16'hD000, 8'h01);
    chk("sim_busy",  64'(slot_busy), 64'h02);
    chk("sim_count", 64'(count),     64'h1);
    chk("sim_idx",   64'(alloc_idx), 64'h1);

    for (int k = 0; k < 3; k++) step("spur_prep", 1'b0, 1'b1, DW'(16'hE000 + k), 8'h00);
    step("spur", 1'b0, 1'b0, 16'h0, 8'hF0);
    chk("spur_busy",  64'(slot_busy), 64'h0F);
    chk("spur_count", 64'(count),     64'h4);

    for (int n = 0; n < 300; n++) begin
      logic          v;
      logic [DW-1:0] d;
      logic [NS-1:0] rel;
      v   = ($urandom_range(0, 9) < 7);
      d   = DW'($urandom);
      rel = NS'($urandom & $urandom & $urandom);
      step("rand", ($urandom_range(0, 99) == 0), v, d, rel);
    end

    step("drain", 1'b0, 1'b0, 16'h0, 8'h00);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
